// File: rtl/seq_alu_if.sv
// Operation/result bundle between the microcode sequencer and the sequential ALU.
// The sequencer side drives the operation; the ALU side returns result and flags.
interface seq_alu_if #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 5
);
    logic                 start;
    logic [3:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [CNT_WIDTH-1:0] count;
    logic                 busy;
    logic                 done;
    logic                 invalid;
    logic [WIDTH-1:0]     out;
    logic                 cf;
    logic                 zf;
    logic                 sf;
    logic                 of;

    modport master (
        output start, op, a, b, count,
        input  busy, done, invalid, out, cf, zf, sf, of
    );

    modport slave (
        input  start, op, a, b, count,
        output busy, done, invalid, out, cf, zf, sf, of
    );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arithmetic ops and bit-serial shifts,
// with a start/done handshake and 8086-style carry/zero/sign/overflow flags.
module seq_alu #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 5
) (
    input  logic      clk,
    input  logic      reset,
    seq_alu_if.slave  io
);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_SELA = 4'd0;
    localparam logic [3:0] OP_SELB = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_SAR  = 4'd9;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t               state, state_n;
    logic [WIDTH-1:0]     acc_p0, acc_n;
    logic [CNT_WIDTH-1:0] rem_p0, rem_n;
    logic [3:0]           op_p0, op_n;
    logic                 one_p0, one_n;
    logic                 msb_p0, msb_n;

    logic [WIDTH-1:0]     out_r, out_n;
    logic                 cf_r, cf_n, zf_r, zf_n, sf_r, sf_n, of_r, of_n;
    logic                 done_r, done_n, inv_r, inv_n;

    logic                 do_step, finish, set_zs;
    logic [3:0]           sh_op;
    logic [WIDTH-1:0]     sh_src;
    logic                 sh_one, sh_msb;
    logic [WIDTH:0]       step;
    logic [WIDTH:0]       wide;

    // Returns {bit shifted out, shifted value} for one bit position.
    function automatic logic [WIDTH:0] shift1(input logic [3:0] sop, input logic [WIDTH-1:0] v);
        logic signed [WIDTH-1:0] sv;
        sv = v;
        case (sop)
            OP_SHL:  shift1 = {v[MSB], v[MSB-1:0], 1'b0};
            OP_SHR:  shift1 = {v[0], 1'b0, v[MSB:1]};
            default: shift1 = {v[0], sv >>> 1};
        endcase
    endfunction

    function automatic logic is_shift(input logic [3:0] sop);
        is_shift = (sop == OP_SHL) || (sop == OP_SHR) || (sop == OP_SAR);
    endfunction

    always_comb begin
        state_n = state;
        acc_n   = acc_p0;
        rem_n   = rem_p0;
        op_n    = op_p0;
        one_n   = one_p0;
        msb_n   = msb_p0;
        out_n   = out_r;
        cf_n    = cf_r;
        zf_n    = zf_r;
        sf_n    = sf_r;
        of_n    = of_r;
        done_n  = 1'b0;
        inv_n   = 1'b0;
        do_step = 1'b0;
        finish  = 1'b0;
        set_zs  = 1'b0;
        sh_op   = op_p0;
        sh_src  = acc_p0;
        sh_one  = one_p0;
        sh_msb  = msb_p0;
        wide    = '0;

        case (state)
            IDLE: begin
                if (io.start) begin
                    done_n = 1'b1;
                    case (io.op)
                        OP_SELA: out_n = io.a;
                        OP_SELB: out_n = io.b;
                        OP_ADD: begin
                            wide   = {1'b0, io.a} + {1'b0, io.b};
                            out_n  = wide[MSB:0];
                            cf_n   = wide[WIDTH];
                            of_n   = (io.a[MSB] == io.b[MSB]) && (wide[MSB] != io.a[MSB]);
                            set_zs = 1'b1;
                        end
                        OP_SUB: begin
                            wide   = {1'b0, io.a} - {1'b0, io.b};
                            out_n  = wide[MSB:0];
                            cf_n   = wide[WIDTH];
                            of_n   = (io.a[MSB] != io.b[MSB]) && (wide[MSB] != io.a[MSB]);
                            set_zs = 1'b1;
                        end
                        OP_XOR, OP_AND, OP_OR: begin
                            out_n  = (io.op == OP_XOR) ? (io.a ^ io.b) :
                                     (io.op == OP_AND) ? (io.a & io.b) : (io.a | io.b);
                            cf_n   = 1'b0;
                            of_n   = 1'b0;
                            set_zs = 1'b1;
                        end
                        OP_SHL, OP_SHR, OP_SAR: begin
                            if (io.count == '0) begin
                                out_n = io.a;
                            end else begin
                                // First bit is shifted on the accepting edge itself.
                                done_n  = 1'b0;
                                do_step = 1'b1;
                                sh_op   = io.op;
                                sh_src  = io.a;
                                sh_one  = (io.count == CNT_WIDTH'(1));
                                sh_msb  = io.a[MSB];
                                op_n    = io.op;
                                one_n   = sh_one;
                                msb_n   = io.a[MSB];
                                rem_n   = io.count - CNT_WIDTH'(1);
                                if (sh_one) finish = 1'b1;
                                else        state_n = SHIFT;
                            end
                        end
                        default: inv_n = 1'b1;
                    endcase
                end
            end
            SHIFT: begin
                do_step = 1'b1;
                rem_n   = rem_p0 - CNT_WIDTH'(1);
                if (rem_p0 == CNT_WIDTH'(1)) begin
                    finish  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        step = shift1(sh_op, sh_src);
        if (do_step) acc_n = step[MSB:0];
        if (finish) begin
            done_n = 1'b1;
            out_n  = step[MSB:0];
            cf_n   = step[WIDTH];
            of_n   = sh_one && ((sh_op == OP_SHL) ? (step[MSB] ^ step[WIDTH]) :
                                (sh_op == OP_SHR) ? sh_msb : 1'b0);
            set_zs = 1'b1;
        end
        if (set_zs) begin
            zf_n = (out_n == '0);
            sf_n = out_n[MSB];
        end
    end

    // Control state and architecturally visible outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            done_r <= 1'b0;
            inv_r  <= 1'b0;
            out_r  <= '0;
            cf_r   <= 1'b0;
            zf_r   <= 1'b0;
            sf_r   <= 1'b0;
            of_r   <= 1'b0;
        end else begin
            state  <= state_n;
            done_r <= done_n;
            inv_r  <= inv_n;
            out_r  <= out_n;
            cf_r   <= cf_n;
            zf_r   <= zf_n;
            sf_r   <= sf_n;
            of_r   <= of_n;
        end
    end

    // Shift working registers; only meaningful while state is SHIFT
    always_ff @(posedge clk) begin
        acc_p0 <= acc_n;
        rem_p0 <= rem_n;
        op_p0  <= op_n;
        one_p0 <= one_n;
        msb_p0 <= msb_n;
    end

    assign io.busy    = (state == SHIFT);
    assign io.done    = done_r;
    assign io.invalid = inv_r;
    assign io.out     = out_r;
    assign io.cf      = cf_r;
    assign io.zf      = zf_r;
    assign io.sf      = sf_r;
    assign io.of      = of_r;

    logic unused_ok;
    assign unused_ok = is_shift(op_p0);
endmodule

// File: tb/tb_seq_alu.sv
// Randomized scoreboard bench for seq_alu: a reference model computes results
// from plain arithmetic and a monitor compares each done pulse against it.
module tb_seq_alu;
    localparam int W  = 16;
    localparam int CW = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(W), .CNT_WIDTH(CW)) io ();
    seq_alu #(.WIDTH(W), .CNT_WIDTH(CW)) dut (.clk(clk), .reset(reset), .io(io));

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [W-1:0] out;
        logic cf, zf, sf, of, inv;
        int unsigned dcyc;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    logic [W-1:0] m_out = '0;
    logic m_cf = 0, m_zf = 0, m_sf = 0, m_of = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    // Reference model: results straight from the arithmetic definitions.
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [CW-1:0] k, input int unsigned acc_cyc);
        exp_t e;
        int r, sa, sb;
        longint v, v2, s;
        bit zs;
        zs = 0;
        e.inv = 0;
        sa = int'($signed(a));
        sb = int'($signed(b));
        e.dcyc = acc_cyc;
        case (op)
            4'd0: m_out = a;
            4'd1: m_out = b;
            4'd2: begin
                r = int'(a) + int'(b);
                m_out = W'(r); m_cf = (r >= 65536);
                m_of = (sa + sb > 32767) || (sa + sb < -32768); zs = 1;
            end
            4'd4: begin
                r = int'(a) - int'(b);
                m_out = W'(r); m_cf = (a < b);
                m_of = (sa - sb > 32767) || (sa - sb < -32768); zs = 1;
            end
            4'd3: begin m_out = a ^ b; m_cf = 0; m_of = 0; zs = 1; end
            4'd5: begin m_out = a & b; m_cf = 0; m_of = 0; zs = 1; end
            4'd6: begin m_out = a | b; m_cf = 0; m_of = 0; zs = 1; end
            4'd7, 4'd8, 4'd9: begin
                if (k == 0) begin
                    m_out = a;
                end else begin
                    e.dcyc = acc_cyc + int'(k) - 1;
                    zs = 1;
                    if (op == 4'd7) begin
                        v = longint'(a) << k;
                        m_out = v[W-1:0]; m_cf = v[W];
                        m_of = (k == 1) ? (m_out[W-1] ^ m_cf) : 1'b0;
                    end else if (op == 4'd8) begin
                        v = longint'(a) >> k;
                        v2 = (longint'(a) << 1) >> k;
                        m_out = v[W-1:0]; m_cf = v2[0];
                        m_of = (k == 1) ? a[W-1] : 1'b0;
                    end else begin
                        s = longint'($signed(a));
                        v = s >>> k;
                        v2 = (s <<< 1) >>> k;
                        m_out = v[W-1:0]; m_cf = v2[0]; m_of = 0;
                    end
                end
            end
            default: e.inv = 1;
        endcase
        if (zs) begin
            m_zf = (m_out == 0);
            m_sf = m_out[W-1];
        end
        e.out = m_out; e.cf = m_cf; e.zf = m_zf; e.sf = m_sf; e.of = m_of;
        sbq.push_back(e);
    endtask

    // Presents an op; while the ALU is busy optionally drives junk starts.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [CW-1:0] k, input bit junk);
        int g;
        g = 0;
        @(negedge clk);
        while (io.busy && g < 100) begin
            io.start = junk;
            io.op    = 4'($urandom);
            io.a     = W'($urandom);
            io.b     = W'($urandom);
            io.count = CW'($urandom);
            @(negedge clk);
            g++;
        end
        if (g >= 100) check("busy_timeout", 1, 0);
        io.start = 1'b1;
        io.op = op; io.a = a; io.b = b; io.count = k;
        model(op, a, b, k, cyc + 1);
        @(posedge clk);
        #1 io.start = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((sbq.size() != 0 || io.busy) && g < 200) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (g >= 200) check("drain_timeout", 1, 0);
    endtask

    always @(negedge clk) begin
        if (!reset && io.done) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = sbq.pop_front();
                check("result", {io.out, io.cf, io.zf, io.sf, io.of, io.invalid},
                      {mon_e.out, mon_e.cf, mon_e.zf, mon_e.sf, mon_e.of, mon_e.inv});
                check("done_cycle", 64'(cyc), 64'(mon_e.dcyc));
            end
        end else if (!reset && io.invalid) begin
            check("invalid_without_done", 1, 0);
        end
    end

    initial begin
        int dcount, bc, g;
        logic [3:0] rop;
        logic [CW-1:0] rk;
        logic [W-1:0] ra, rb;
        io.start = 0; io.op = 0; io.a = 0; io.b = 0; io.count = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {io.busy, io.done, io.invalid, io.out, io.cf, io.zf, io.sf, io.of}, 0);
        reset = 1'b0;
        dcount = 0;
        repeat (10) begin
            @(negedge clk);
            if (io.done) dcount++;
        end
        check("idle_no_done", dcount, 0);
        check("idle_outputs", {io.busy, io.out, io.cf, io.zf, io.sf, io.of}, 0);

        issue(4'd2, 16'hFFFF, 16'h0001, 0, 0);
        wait_idle();
        check("add_wrap", {io.out, io.cf, io.zf, io.of}, {16'h0000, 1'b1, 1'b1, 1'b0});
        issue(4'd4, 16'h8000, 16'h0001, 0, 0);
        wait_idle();
        check("sub_ovf", {io.out, io.of, io.cf}, {16'h7FFF, 1'b1, 1'b0});
        issue(4'd7, 16'h8001, 16'h0000, 1, 0);
        wait_idle();
        check("shl_1", {io.out, io.cf, io.of}, {16'h0002, 1'b1, 1'b1});

        issue(4'd9, 16'h8000, 16'h0000, 20, 0);
        bc = 0; g = 0;
        while (g < 100) begin
            @(negedge clk);
            if (io.done) break;
            if (io.busy) bc++;
            g++;
        end
        check("sar20_busy_cycles", bc, 19);
        wait_idle();
        check("sar20", {io.out, io.cf}, {16'hFFFF, 1'b1});

        issue(4'd8, 16'hB6C3, 16'h0000, 4, 0);
        issue(4'd2, 16'h1234, 16'h4321, 0, 1);
        wait_idle();

        issue(4'd2, 16'hFFFF, 16'h0002, 0, 0);
        issue(4'd1, 16'h1234, 16'h5678, 0, 0);
        wait_idle();
        check("selb_keeps_cf", {io.out, io.cf}, {16'h5678, 1'b1});
        issue(4'd12, 16'hAAAA, 16'h5555, 0, 0);
        wait_idle();
        check("invalid_holds_out", io.out, 16'h5678);

        issue(4'd7, 16'h00F0, 16'h0000, 8, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        sbq.delete();
        m_out = '0; m_cf = 0; m_zf = 0; m_sf = 0; m_of = 0;
        @(negedge clk);
        check("mid_shift_reset", {io.busy, io.done, io.invalid, io.out, io.cf, io.zf, io.sf, io.of}, 0);
        reset = 1'b0;
        dcount = 0;
        repeat (12) begin
            @(negedge clk);
            if (io.done) dcount++;
        end
        check("no_done_after_reset", dcount, 0);

        repeat (300) begin
            rop = 4'($urandom_range(0, 15));
            rk  = ($urandom % 4 == 0) ? CW'($urandom_range(0, 31)) : CW'($urandom_range(0, 3));
            ra  = ($urandom % 5 == 0) ? 16'h8000 : W'($urandom);
            rb  = ($urandom % 5 == 0) ? ra : W'($urandom);
            issue(rop, ra, rb, rk, bit'($urandom % 2));
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
